// File: rtl/request_arbiter_pkg.sv
// Shared types for the request arbiter: FSM state encodings.
package request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_ACK = 2'b01,
    RELEASE  = 2'b10
  } state_t;

endpackage

// File: rtl/priority_encoder_rotate.sv
// Combinational rotating priority search: first valid at or after start, wrapping.
module priority_encoder_rotate
  import request_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST      = 4,
  parameter int NUM_REQUEST_LOG2 = 2
) (
  input  logic [NUM_REQUEST-1:0]      valid,
  input  logic [NUM_REQUEST_LOG2-1:0] start,
  output logic [NUM_REQUEST_LOG2-1:0] index,
  output logic                        found
);

  int                          k;
  logic [NUM_REQUEST_LOG2-1:0] idx;

  always_comb begin
    index = '0;
    found = 1'b0;
    k     = 0;
    idx   = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      k   = (int'(start) + i) % NUM_REQUEST;
      idx = NUM_REQUEST_LOG2'(k);
      if (!found && valid[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/request_arbiter.sv
// Single-outstanding request arbiter; define REQUEST_ARBITER_ROUND_ROBIN_EN
// for round-robin search, otherwise fixed lowest-index priority.
module request_arbiter
  import request_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST                  = 4,
  parameter int NUM_REQUEST_LOG2             = 2,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 32
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUEST-1:0]                              request_valid_packed_in,
  output logic [NUM_REQUEST-1:0]                              issue_ack_packed_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
  output logic                                                request_valid_out,
  input  logic                                                issue_ack_in,
  output logic [NUM_REQUEST_LOG2-1:0]                         grant_index_out
);

  localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;

  state_t                      state, state_n;
  logic [W-1:0]                payload [NUM_REQUEST];
  logic [W-1:0]                req_n;
  logic                        vld_n;
  logic [NUM_REQUEST-1:0]      ack_n;
  logic [NUM_REQUEST_LOG2-1:0] gnt_n;
  logic [NUM_REQUEST_LOG2-1:0] start;
  logic [NUM_REQUEST_LOG2-1:0] win;
  logic                        found;

  for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_pay
    assign payload[i] = request_packed_in[i*W +: W];
  end

`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
  logic [NUM_REQUEST_LOG2-1:0] ptr;

  assign start = (int'(ptr) == NUM_REQUEST - 1) ? '0 : ptr + 1'b1;

  // Pointer tracks the last winner so the next search starts just past it
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      ptr <= NUM_REQUEST_LOG2'(NUM_REQUEST - 1);
    else if (state == IDLE && found)
      ptr <= win;
  end
`else
  assign start = '0;
`endif

  priority_encoder_rotate #(
    .NUM_REQUEST      (NUM_REQUEST),
    .NUM_REQUEST_LOG2 (NUM_REQUEST_LOG2)
  ) u_pe (
    .valid (request_valid_packed_in),
    .start (start),
    .index (win),
    .found (found)
  );

  always_comb begin
    state_n = state;
    req_n   = request_out;
    vld_n   = request_valid_out;
    ack_n   = '0;
    gnt_n   = grant_index_out;
    unique case (state)
      IDLE: begin
        vld_n = 1'b0;
        if (found) begin
          req_n   = payload[win];
          vld_n   = 1'b1;
          gnt_n   = win;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (issue_ack_in) begin
          vld_n                  = 1'b0;
          ack_n[grant_index_out] = 1'b1;
          state_n                = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state                <= IDLE;
      request_out          <= '0;
      request_valid_out    <= 1'b0;
      issue_ack_packed_out <= '0;
      grant_index_out      <= '0;
    end else begin
      state                <= state_n;
      request_out          <= req_n;
      request_valid_out    <= vld_n;
      issue_ack_packed_out <= ack_n;
      grant_index_out      <= gnt_n;
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// Directed self-checking bench for request_arbiter.
module tb_request_arbiter;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic [127:0] request_packed_in;
  logic [3:0]   request_valid_packed_in;
  logic [3:0]   issue_ack_packed_out;
  logic [31:0]  request_out;
  logic         request_valid_out;
  logic         issue_ack_in;
  logic [1:0]   grant_index_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pay [4];
  int          exp_g;

  request_arbiter dut (
    .clk_in                  (clk_in),
    .reset_in                (reset_in),
    .request_packed_in       (request_packed_in),
    .request_valid_packed_in (request_valid_packed_in),
    .issue_ack_packed_out    (issue_ack_packed_out),
    .request_out             (request_out),
    .request_valid_out       (request_valid_out),
    .issue_ack_in            (issue_ack_in),
    .grant_index_out         (grant_index_out)
  );

  always #5 clk_in = ~clk_in;

  always_comb
    for (int i = 0; i < 4; i++)
      request_packed_in[i*32 +: 32] = pay[i];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    pay[0] = 32'h1000_0000;
    pay[1] = 32'h1111_1111;
    pay[2] = 32'hDEAD_BEEF;
    pay[3] = 32'h3333_3333;
    request_valid_packed_in = '0;
    issue_ack_in = 1'b0;
    reset_in = 1'b1;
    tick();
    tick();
    chk("rst_req", request_out, 32'h0);
    chk("rst_vld", {31'd0, request_valid_out}, 32'd0);
    chk("rst_ack", {28'd0, issue_ack_packed_out}, 32'd0);
    chk("rst_gnt", {30'd0, grant_index_out}, 32'd0);
    reset_in = 1'b0;
    tick();
    chk("idle_vld", {31'd0, request_valid_out}, 32'd0);

    // single request on index 2, winner drops valid while waiting
    request_valid_packed_in = 4'b0100;
    tick();
    chk("one_req", request_out, 32'hDEAD_BEEF);
    chk("one_vld", {31'd0, request_valid_out}, 32'd1);
    chk("one_gnt", {30'd0, grant_index_out}, 32'd2);
    request_valid_packed_in = 4'b0000;
    tick();
    chk("one_hold", {31'd0, request_valid_out}, 32'd1);
    issue_ack_in = 1'b1;
    tick();
    chk("one_ack", {28'd0, issue_ack_packed_out}, 32'h4);
    chk("one_vld0", {31'd0, request_valid_out}, 32'd0);
    issue_ack_in = 1'b0;
    tick();
    chk("one_ack0", {28'd0, issue_ack_packed_out}, 32'h0);

    // spurious ack in idle
    issue_ack_in = 1'b1;
    tick();
    chk("spur_ack", {28'd0, issue_ack_packed_out}, 32'h0);
    chk("spur_vld", {31'd0, request_valid_out}, 32'd0);
    tick();
    chk("spur_ack2", {28'd0, issue_ack_packed_out}, 32'h0);
    issue_ack_in = 1'b0;

    // downstream stall with changing inputs
    request_valid_packed_in = 4'b1000;
    tick();
    chk("stall_gnt", {30'd0, grant_index_out}, 32'd3);
    request_valid_packed_in = 4'b0001;
    pay[3] = 32'hCAFE_0003;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_req", request_out, 32'h3333_3333);
      chk("stall_gnt_h", {30'd0, grant_index_out}, 32'd3);
      chk("stall_ack", {28'd0, issue_ack_packed_out}, 32'h0);
      chk("stall_vld", {31'd0, request_valid_out}, 32'd1);
    end
    pay[3] = 32'h3333_3333;
    request_valid_packed_in = 4'b0000;
    issue_ack_in = 1'b1;
    tick();
    chk("stall_ackp", {28'd0, issue_ack_packed_out}, 32'h8);
    issue_ack_in = 1'b0;
    tick();

    // all requesters valid continuously
    request_valid_packed_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
      exp_g = k % 4;
`else
      exp_g = 0;
`endif
      tick();
      chk("all_gnt", {30'd0, grant_index_out}, 32'(exp_g));
      chk("all_req", request_out, pay[exp_g]);
      chk("all_vld", {31'd0, request_valid_out}, 32'd1);
      issue_ack_in = 1'b1;
      tick();
      chk("all_ack", {28'd0, issue_ack_packed_out}, 32'(1 << exp_g));
      issue_ack_in = 1'b0;
      tick();
      chk("all_rel", {28'd0, issue_ack_packed_out}, 32'h0);
      chk("all_rel_v", {31'd0, request_valid_out}, 32'd0);
    end

    // reset while waiting for ack
    request_valid_packed_in = 4'b0010;
    tick();
    chk("mr_gnt", {30'd0, grant_index_out}, 32'd1);
    issue_ack_in = 1'b1;
    reset_in = 1'b1;
    #1;
    chk("mr_req", request_out, 32'h0);
    chk("mr_vld", {31'd0, request_valid_out}, 32'd0);
    chk("mr_gnt0", {30'd0, grant_index_out}, 32'd0);
    tick();
    chk("mr_ack", {28'd0, issue_ack_packed_out}, 32'h0);
    reset_in = 1'b0;
    issue_ack_in = 1'b0;
    request_valid_packed_in = 4'b1111;
    tick();
    chk("mr_next", {30'd0, grant_index_out}, 32'd0);
    chk("mr_next_r", request_out, 32'h1000_0000);
    chk("mr_ack2", {28'd0, issue_ack_packed_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/request_arbiter.md
REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUEST, default 4, meaning number of upstream requesters.
REQ-002 SHALL have parameter NUM_REQUEST_LOG2, default 2, meaning width of the grant index.
REQ-003 SHALL have parameter SINGLE_REQUEST_WIDTH_IN_BITS, default 32, meaning payload width per request.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock, all state on rising edge.
REQ-006 SHALL have port reset_in, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port request_packed_in, input, NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS bits: payload i in slice i.
REQ-008 SHALL have port request_valid_packed_in, input, NUM_REQUEST bits: per-requester valid.
REQ-009 SHALL have port issue_ack_packed_out, output reg, NUM_REQUEST bits: per-requester one-cycle accept pulse.
REQ-010 SHALL have port request_out, output reg, SINGLE_REQUEST_WIDTH_IN_BITS bits: granted payload to the downstream FIFO.
REQ-011 SHALL have port request_valid_out, output reg, 1 bit: granted payload valid.
REQ-012 SHALL have port issue_ack_in, input, 1 bit: downstream FIFO accept.
REQ-013 SHALL have port grant_index_out, output reg, NUM_REQUEST_LOG2 bits: index of the current or last winner.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WAIT_ACK, RELEASE.
REQ-015 IDLE: if any request_valid_packed_in bit is set, SHALL register the winner's payload into request_out, set request_valid_out=1 and grant_index_out=winner, and go to WAIT_ACK next cycle; otherwise SHALL stay in IDLE with request_valid_out=0.
REQ-016 WAIT_ACK: SHALL hold request_out, request_valid_out and grant_index_out stable until issue_ack_in is sampled high, ignoring later changes on request inputs.
REQ-017 On issue_ack_in sampled high in WAIT_ACK, SHALL at that edge clear request_valid_out, set issue_ack_packed_out[grant] for exactly one cycle, and enter RELEASE.
REQ-018 RELEASE: SHALL ignore all request inputs for one cycle so the acked requester can drop valid, then return to IDLE.
REQ-019 Latency: SHALL present a winner on request_out one cycle after its valid is sampled in IDLE; minimum spacing between grants SHALL be 3 cycles.
REQ-020 issue_ack_packed_out SHALL be one-hot or zero at all times.
REQ-021 If the winner drops valid while in WAIT_ACK, the request SHALL still complete (no withdrawal).
REQ-022 issue_ack_in asserted outside WAIT_ACK SHALL be ignored.
REQ-023 Priority search SHALL wrap from index NUM_REQUEST-1 to 0.

Reset
REQ-024 On reset_in high, SHALL asynchronously force state=IDLE, request_out=0, request_valid_out=0, issue_ack_packed_out=0, grant_index_out=0, and round-robin pointer=NUM_REQUEST-1.
REQ-025 Reset in WAIT_ACK SHALL drop the pending request without issuing any ack.

Configuration
REQ-026 With macro REQUEST_ARBITER_ROUND_ROBIN_EN defined, SHALL search for the winner starting at (last winner + 1) mod NUM_REQUEST, updating the pointer on each grant.
REQ-027 Without REQUEST_ARBITER_ROUND_ROBIN_EN, SHALL grant the lowest-index valid requester (fixed priority), with no pointer register.

Structure
REQ-028 SHALL place the FSM state encodings (IDLE=2'b00, WAIT_ACK=2'b01, RELEASE=2'b10) in the shared package.
REQ-029 SHALL factor winner selection into one combinational sub-module, priority_encoder_rotate, taking the valid vector and start index and returning the winner index and a found flag.

Verification
REQ-030 SHALL cover a single request: valid[2]=1 with payload 0xDEAD_BEEF -> request_out=0xDEADBEEF and valid_out=1 next cycle; ack_in high one cycle -> issue_ack_packed_out=4'b0100 for one cycle.
REQ-031 SHALL cover round robin (macro on): all 4 valid continuously, ack_in after 1 cycle each -> grants in order 0,1,2,3,0.
REQ-032 SHALL cover fixed priority (macro off): all 4 valid continuously -> grant_index_out=0 every grant.
REQ-033 SHALL cover downstream stall: ack_in held low 10 cycles -> request_out and grant_index_out stable, no ack pulse.
REQ-034 SHALL cover mid-operation reset: reset_in asserted in WAIT_ACK -> all outputs 0 immediately, no ack pulse, and the next grant goes to index 0.
REQ-035 SHALL cover a spurious ack: ack_in high in IDLE with no valid -> no state change and issue_ack_packed_out=0.
